// File: rtl/nibble_add_seq.sv
// Nibble-serial adder/subtractor: one 4-bit adder slice is reused for NIBBLES
// cycles, LSB nibble first, and the full-width result is registered on completion.
module nibble_add_seq #(
    parameter int NIBBLES = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [4*NIBBLES-1:0]   a,
    input  logic [4*NIBBLES-1:0]   b,
    input  logic                   cin,
    input  logic                   sub,
    output logic                   busy,
    output logic                   done,
    output logic [4*NIBBLES-1:0]   s,
    output logic                   cout,
    output logic                   ovf
);

    localparam int W  = 4 * NIBBLES;
    localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(NIBBLES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state_r;
    state_t          next_state_s;
    logic [W-1:0]    a_r;
    logic [W-1:0]    b_r;
    logic            carry_r;
    logic [IW-1:0]   idx_r;
    logic [W-1:0]    res_r;
    logic [W-1:0]    s_r;
    logic            cout_r;
    logic            ovf_r;
    logic            busy_r;
    logic            done_r;

    logic            load_s;
    logic            last_s;
    logic [3:0]      x_s;
    logic [3:0]      y_s;
    logic [3:0]      lo_s;
    logic [1:0]      hi_s;
    logic            c3_s;
    logic [3:0]      sum_s;
    logic            co_s;
    logic [W-1:0]    final_s;

    // Single 4-bit slice; carry into bit 3 is kept separately for overflow detection
    always_comb begin
        x_s   = a_r[{idx_r, 2'b00} +: 4];
        y_s   = b_r[{idx_r, 2'b00} +: 4];
        lo_s  = {1'b0, x_s[2:0]} + {1'b0, y_s[2:0]} + {3'b000, carry_r};
        c3_s  = lo_s[3];
        hi_s  = {1'b0, x_s[3]} + {1'b0, y_s[3]} + {1'b0, c3_s};
        sum_s = {hi_s[0], lo_s[2:0]};
        co_s  = hi_s[1];
    end

    // Result as it will look once the current nibble is written back
    always_comb begin
        final_s = res_r;
        final_s[{idx_r, 2'b00} +: 4] = sum_s;
    end

    // Next-state logic; a new operation may be accepted from IDLE or straight out of DONE
    always_comb begin
        next_state_s = state_r;
        load_s       = 1'b0;
        last_s       = (idx_r == LAST_IDX);
        case (state_r)
            IDLE: begin
                if (start) begin
                    next_state_s = RUN;
                    load_s       = 1'b1;
                end else begin
                    next_state_s = IDLE;
                end
            end
            RUN: begin
                if (last_s) begin
                    next_state_s = DONE;
                end else begin
                    next_state_s = RUN;
                end
            end
            DONE: begin
                if (start) begin
                    next_state_s = RUN;
                    load_s       = 1'b1;
                end else begin
                    next_state_s = IDLE;
                end
            end
            default: begin
                next_state_s = IDLE;
            end
        endcase
    end

    // State register with registered status flags
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= next_state_s;
            busy_r  <= (next_state_s == RUN);
            done_r  <= (next_state_s == DONE);
        end
    end

    // Operand capture, per-nibble accumulation and result publication
    always_ff @(posedge clk) begin
        if (rst) begin
            a_r     <= {W{1'b0}};
            b_r     <= {W{1'b0}};
            carry_r <= 1'b0;
            idx_r   <= {IW{1'b0}};
            res_r   <= {W{1'b0}};
            s_r     <= {W{1'b0}};
            cout_r  <= 1'b0;
            ovf_r   <= 1'b0;
        end else begin
            if (load_s) begin
                // Subtraction is a + ~b + 1, so invert b and force the carry
                a_r     <= a;
                b_r     <= sub ? ~b : b;
                carry_r <= sub ? 1'b1 : cin;
                idx_r   <= {IW{1'b0}};
            end else if (state_r == RUN) begin
                res_r[{idx_r, 2'b00} +: 4] <= sum_s;
                carry_r <= co_s;
                idx_r   <= idx_r + IW'(1);
            end
            if ((state_r == RUN) && last_s) begin
                s_r    <= final_s;
                cout_r <= co_s;
                ovf_r  <= c3_s ^ co_s;
            end
        end
    end

    assign busy = busy_r;
    assign done = done_r;
    assign s    = s_r;
    assign cout = cout_r;
    assign ovf  = ovf_r;

endmodule

// File: tb/tb_nibble_add_seq.sv
// Randomised and directed bench for nibble_add_seq (NIBBLES=4) against an
// arithmetic reference model.
module tb_nibble_add_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic        sub;
    logic        busy;
    logic        done;
    logic [15:0] s;
    logic        cout;
    logic        ovf;

    int errors = 0;
    int checks = 0;

    logic [17:0] exp_res;   // {ovf, cout, s} expected for the pending operation
    logic [17:0] last_res;  // {ovf, cout, s} the outputs must currently hold

    always #5 clk = ~clk;

    nibble_add_seq #(.NIBBLES(4)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .sub   (sub),
        .busy  (busy),
        .done  (done),
        .s     (s),
        .cout  (cout),
        .ovf   (ovf)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference: plain modular arithmetic, sign-rule overflow
    function automatic logic [17:0] model(input logic [15:0] ma, input logic [15:0] mb,
                                          input logic mc, input logic ms);
        logic [16:0] full;
        logic [15:0] r;
        logic        co;
        logic        ov;
        if (ms) begin
            full = 17'(ma) - 17'(mb);
            co   = (ma >= mb);
        end else begin
            full = 17'(ma) + 17'(mb) + 17'(mc);
            co   = full[16];
        end
        r  = full[15:0];
        ov = ms ? ((ma[15] != mb[15]) && (r[15] != ma[15]))
                : ((ma[15] == mb[15]) && (r[15] != ma[15]));
        return {ov, co, r};
    endfunction

    task automatic launch(input logic [15:0] ta, input logic [15:0] tb2,
                          input logic tc, input logic ts);
        a       = ta;
        b       = tb2;
        cin     = tc;
        sub     = ts;
        start   = 1'b1;
        exp_res = model(ta, tb2, tc, ts);
    endtask

    // Sample the start edge, watch 4 RUN cycles with scrambled inputs, check DONE
    task automatic finish(input string tag, input bit hold);
        step();
        if (!hold) start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            a   = 16'($urandom);
            b   = 16'($urandom);
            cin = 1'($urandom);
            sub = 1'($urandom);
            check({tag, "_run_flags"}, 32'({busy, done}), 32'(2'b10));
            check({tag, "_run_hold"}, 32'({ovf, cout, s}), 32'(last_res));
            step();
        end
        check({tag, "_done_flags"}, 32'({busy, done}), 32'(2'b01));
        check({tag, "_result"}, 32'({ovf, cout, s}), 32'(exp_res));
        last_res = exp_res;
    endtask

    task automatic idle_check(input string tag);
        start = 1'b0;
        step();
        check({tag, "_idle_flags"}, 32'({busy, done}), 32'(2'b00));
        check({tag, "_idle_hold"}, 32'({ovf, cout, s}), 32'(last_res));
    endtask

    typedef struct {
        logic [15:0] da;
        logic [15:0] db;
        logic        dc;
        logic        ds;
    } op_t;

    op_t dir_ops[8];

    initial begin
        dir_ops[0] = '{16'h0001, 16'h0000, 1'b0, 1'b0};
        dir_ops[1] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0};
        dir_ops[2] = '{16'h000B, 16'h0006, 1'b0, 1'b0};
        dir_ops[3] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0};
        dir_ops[4] = '{16'h0002, 16'h0004, 1'b1, 1'b0};
        dir_ops[5] = '{16'h0005, 16'h0003, 1'b1, 1'b1};
        dir_ops[6] = '{16'h0003, 16'h0005, 1'b0, 1'b1};
        dir_ops[7] = '{16'h8000, 16'h0001, 1'b0, 1'b1};

        rst      = 1'b1;
        start    = 1'b0;
        a        = 16'h0000;
        b        = 16'h0000;
        cin      = 1'b0;
        sub      = 1'b0;
        last_res = 18'h0;
        exp_res  = 18'h0;
        step();
        step();
        check("reset_state", 32'({busy, done, ovf, cout, s}), 32'(0));
        rst = 1'b0;
        idle_check("post_reset");

        // Directed corner cases
        for (int i = 0; i < 8; i++) begin
            launch(dir_ops[i].da, dir_ops[i].db, dir_ops[i].dc, dir_ops[i].ds);
            finish($sformatf("dir%0d", i), 1'b0);
            idle_check($sformatf("dir%0d", i));
        end
        // Independent spot checks on the documented values
        launch(16'h7FFF, 16'h0001, 1'b0, 1'b0);
        finish("ovf_add", 1'b0);
        check("ovf_add_const", 32'({ovf, cout, s}), 32'({1'b1, 1'b0, 16'h8000}));
        idle_check("ovf_add");
        launch(16'h0003, 16'h0005, 1'b1, 1'b1);
        finish("borrow", 1'b0);
        check("borrow_const", 32'({cout, s}), 32'({1'b0, 16'hFFFE}));

        // start held through RUN, then back-to-back accept from DONE
        launch(16'h1234, 16'h4321, 1'b0, 1'b0);
        finish("hold", 1'b1);
        launch(16'h00FF, 16'h0F01, 1'b1, 1'b0);
        finish("b2b", 1'b0);
        idle_check("b2b");

        // Reset during the 3rd RUN cycle aborts the operation
        launch(16'hABCD, 16'h1111, 1'b0, 1'b0);
        step();
        start = 1'b0;
        step();
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("abort_outputs", 32'({busy, done, ovf, cout, s}), 32'(0));
        last_res = 18'h0;
        for (int i = 0; i < 6; i++) begin
            check("abort_no_done", 32'({busy, done}), 32'(2'b00));
            step();
        end
        launch(16'h0F0F, 16'h00F1, 1'b0, 1'b0);
        finish("after_abort", 1'b0);
        idle_check("after_abort");

        // Reset wins over start on the same edge
        launch(16'h0001, 16'h0001, 1'b0, 1'b0);
        rst = 1'b1;
        step();
        rst   = 1'b0;
        start = 1'b0;
        check("rst_prio", 32'({busy, done, ovf, cout, s}), 32'(0));
        last_res = 18'h0;
        step();
        check("rst_prio_idle", 32'({busy, done}), 32'(2'b00));

        // Random operations, randomly chained back-to-back
        for (int i = 0; i < 30; i++) begin
            launch(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));
            finish($sformatf("rnd%0d", i), 1'b0);
            if ($urandom_range(1, 0) == 0) idle_check($sformatf("rnd%0d", i));
        end
        idle_check("final");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
